// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   FRAME_BITS / DATA_BITS   : frame geometry (start + 8 data + parity + stop)
//   *_POS / DATA_LSB         : bit positions inside the 11-bit frame word
//   uart_tx_state_t          : transmit framer FSM encoding
//   calc_parity()            : even (odd=0) or odd (odd=1) parity of a data byte
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam int START_POS  = 0;
  localparam int DATA_LSB   = 1;
  localparam int PARITY_POS = 9;
  localparam int STOP_POS   = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle bit_end pulse in the cycle the counter sits at CLKS_PER_BIT-1,
// then wraps to 0.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the counter to 0 (start of a new frame)
//   enable     : count this cycle
//   bit_end    : last cycle of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        bit_end = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
// Transmit half of the UART link. Accepts one byte per valid/ready handshake,
// builds the frame {stop, parity, data[7:0], start} and shifts it out LSB
// first on serial_out, each bit held CLKS_PER_BIT cycles.
//   clk, reset  : clock, synchronous active-high reset
//   tx_valid    : host presents tx_data
//   tx_data     : byte to send, sampled only on the handshake
//   tx_ready    : high in IDLE
//   serial_out  : registered TX line, idles high
//   busy        : frame in progress (any state but IDLE)
//   done_flag   : one-cycle pulse in the cycle after the stop bit ends
//   state_dbg   : current FSM state, for observation only
//
// Handshake: a byte transfers at a rising edge where tx_valid & tx_ready are
// both high. The host must keep tx_valid (and tx_data) stable until then;
// tx_valid/tx_data are ignored while busy.
// ---------------------------------------------------------------------------
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done_flag,
  output uart_tx_state_t       state_dbg
);

  uart_tx_state_t         state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   serial_out_q, serial_out_d;
  logic                   done_q, done_d;
  logic                   baud_clear;
  logic                   bit_end;
  logic [FRAME_BITS-1:0]  frame;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .enable  (state_q != IDLE),
    .bit_end (bit_end)
  );

  // Frame word assembled at the handshake; bit 0 goes on the line first.
  always_comb begin
    frame                          = '0;
    frame[START_POS]               = 1'b0;
    frame[DATA_LSB +: DATA_BITS]   = tx_data;
    frame[PARITY_POS]              = calc_parity(tx_data, PARITY_ODD != 0);
    frame[STOP_POS]                = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    baud_clear = 1'b0;

    // Every bit period end moves the next frame bit into position 0;
    // ones are shifted in so an emptied register reads as idle line.
    if (state_q != IDLE && bit_end) begin
      shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d    = frame;
          bit_idx_d  = '0;
          baud_clear = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line value is registered from the next-state view so each bit
    // appears on the edge that enters its period.
    serial_out_d = (state_d == IDLE) ? 1'b1 : shift_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '1;
      serial_out_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      done_q       <= done_d;
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_out_q;
  assign done_flag  = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
// Three framer instances share one clock:
//   lane 0 : CLKS_PER_BIT=4, even parity
//   lane 1 : CLKS_PER_BIT=4, odd parity
//   lane 2 : CLKS_PER_BIT=2, even parity
// Drivers push the hand-computed 11-bit frame {stop,parity,data,start} into
// the lane's expected queue; the monitor pops it when it sees the handshake
// and checks the line bit by bit, plus busy/ready/done_flag around it.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int LANES = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     [LANES];
  logic       tx_valid  [LANES];
  logic [7:0] tx_data   [LANES];
  logic       tx_ready  [LANES];
  logic       serial_out[LANES];
  logic       busy      [LANES];
  logic       done_flag [LANES];
  logic [2:0] state_dbg [LANES];

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .busy(busy[0]),
    .done_flag(done_flag[0]), .state_dbg(state_dbg[0]));

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .busy(busy[1]),
    .done_flag(done_flag[1]), .state_dbg(state_dbg[1]));

  uart_tx_framer #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .reset(reset[2]), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
    .tx_ready(tx_ready[2]), .serial_out(serial_out[2]), .busy(busy[2]),
    .done_flag(done_flag[2]), .state_dbg(state_dbg[2]));

  function automatic int lane_cpb(input int l);
    return (l == 2) ? 2 : 4;
  endfunction

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];
  int checks = 0;
  int errors = 0;

  function automatic void push_exp(input int l, input logic [10:0] f);
    case (l)
      0:       exp_q0.push_back(f);
      1:       exp_q1.push_back(f);
      default: exp_q2.push_back(f);
    endcase
  endfunction

  function automatic int exp_size(input int l);
    case (l)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [10:0] pop_exp(input int l);
    case (l)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void chk(input string name, input int l,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got %0h expected %0h at %0t", name, l, act, exp, $time);
    end
  endfunction

  function automatic void note_fail(input string name, input int l);
    checks++;
    errors++;
    $display("FAIL %s lane%0d at %0t", name, l, $time);
  endfunction

  // ---------------- monitor ----------------
  logic        mon_active    [LANES];
  logic        mon_done      [LANES];
  logic        mon_prev_ready[LANES];
  int          mon_pos       [LANES];
  logic [10:0] mon_frame     [LANES];

  initial begin
    for (int l = 0; l < LANES; l++) begin
      mon_active[l]     = 1'b0;
      mon_done[l]       = 1'b0;
      mon_prev_ready[l] = 1'b0;
      mon_pos[l]        = 0;
      mon_frame[l]      = '1;
    end
  end

  // Samples 1 time unit after each rising edge; inputs only change on the
  // falling edge, so the sampled inputs are the ones that edge saw.
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < LANES; l++) begin
      if (reset[l]) begin
        mon_active[l] = 1'b0;
        mon_done[l]   = 1'b0;
        chk("rst_serial_out", l, 32'(serial_out[l]), 32'd1);
        chk("rst_tx_ready",   l, 32'(tx_ready[l]),   32'd1);
        chk("rst_busy",       l, 32'(busy[l]),       32'd0);
        chk("rst_done_flag",  l, 32'(done_flag[l]),  32'd0);
        chk("rst_state",      l, 32'(state_dbg[l]),  32'd0);
      end else begin
        if (tx_valid[l] && mon_prev_ready[l]) begin
          if (exp_size(l) == 0) begin
            note_fail("unexpected_handshake", l);
          end else begin
            mon_frame[l]  = pop_exp(l);
            mon_active[l] = 1'b1;
            mon_done[l]   = 1'b0;
            mon_pos[l]    = 0;
          end
        end
        if (mon_active[l]) begin
          logic [10:0] sh;
          sh = mon_frame[l] >> (mon_pos[l] / lane_cpb(l));
          chk($sformatf("line_bit%0d", mon_pos[l] / lane_cpb(l)), l,
              32'(serial_out[l]), 32'(sh[0]));
          chk("frame_busy",  l, 32'(busy[l]),      32'd1);
          chk("frame_ready", l, 32'(tx_ready[l]),  32'd0);
          chk("frame_done",  l, 32'(done_flag[l]), 32'd0);
          mon_pos[l]++;
          if (mon_pos[l] == 11 * lane_cpb(l)) begin
            mon_active[l] = 1'b0;
            mon_done[l]   = 1'b1;
          end
        end else if (mon_done[l]) begin
          chk("end_done_flag",  l, 32'(done_flag[l]),  32'd1);
          chk("end_tx_ready",   l, 32'(tx_ready[l]),   32'd1);
          chk("end_serial_out", l, 32'(serial_out[l]), 32'd1);
          chk("end_busy",       l, 32'(busy[l]),       32'd0);
          mon_done[l] = 1'b0;
        end else begin
          chk("idle_done_flag",  l, 32'(done_flag[l]),  32'd0);
          chk("idle_serial_out", l, 32'(serial_out[l]), 32'd1);
        end
      end
      mon_prev_ready[l] = tx_ready[l];
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic wait_ready(input int l);
    int n = 0;
    while (!tx_ready[l] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[l]) note_fail("ready_timeout", l);
  endtask

  task automatic send(input int l, input logic [7:0] d, input logic [10:0] f);
    push_exp(l, f);
    tx_valid[l] = 1'b1;
    tx_data[l]  = d;
    wait_ready(l);
    @(negedge clk);
    tx_valid[l] = 1'b0;
    tx_data[l]  = ~d;   // scribble while busy; must not reach the line
  endtask

  task automatic wait_idle();
    for (int l = 0; l < LANES; l++) begin
      int n = 0;
      while ((busy[l] || mon_active[l]) && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (busy[l]) note_fail("idle_timeout", l);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held 3 cycles with tx_valid high: nothing may be accepted.
    for (int l = 0; l < LANES; l++) begin
      reset[l]    = 1'b1;
      tx_valid[l] = 1'b1;
      tx_data[l]  = 8'h55;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < LANES; l++) begin
      reset[l]    = 1'b0;
      tx_valid[l] = 1'b0;
      tx_data[l]  = 8'h00;
    end
    repeat (2) @(negedge clk);

    // Single frames: parity flavours and the short-bit-period boundary.
    fork
      begin
        send(0, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0});  // even parity of A5 = 0
        send(0, 8'h01, {1'b1, 1'b1, 8'h01, 1'b0});  // even parity of 01 = 1
      end
      begin
        send(1, 8'h01, {1'b1, 1'b0, 8'h01, 1'b0});  // odd parity of 01 = 0
        send(1, 8'hC3, {1'b1, 1'b1, 8'hC3, 1'b0});  // odd parity of C3 = 1
      end
      begin
        send(2, 8'h80, {1'b1, 1'b1, 8'h80, 1'b0});  // 22-cycle frame
        send(2, 8'h7E, {1'b1, 1'b0, 8'h7E, 1'b0});
      end
    join
    wait_idle();

    // Back-to-back 00 then FF with tx_valid held high throughout.
    push_exp(0, {1'b1, 1'b0, 8'h00, 1'b0});
    push_exp(0, {1'b1, 1'b0, 8'hFF, 1'b0});
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h00;
    wait_ready(0);
    @(negedge clk);
    tx_data[0] = 8'hFF;   // changes during frame 1
    wait_ready(0);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    tx_data[0]  = 8'h00;
    wait_idle();

    // Reset in the middle of DATA aborts the frame; next byte is clean.
    send(0, 8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0});
    repeat (19) @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    repeat (2) @(negedge clk);
    send(0, 8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0});
    wait_idle();

    // Every expected frame must have been transmitted.
    for (int l = 0; l < LANES; l++) begin
      chk("leftover_frames", l, 32'(exp_size(l)), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global safety net.
  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
